// File: rtl/ro_pkg.sv
// Shared types, word tags and field positions for the CDS row packer.
package ro_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CAP_R,
        WAIT_S,
        CAP_S,
        SER
    } ro_state_e;

    localparam logic [1:0] TAG_HDR  = 2'b10;
    localparam logic [1:0] TAG_DATA = 2'b01;

    localparam int WORD_W   = 32;
    localparam int TAG_LSB  = 30;
    localparam int ROW_LSB  = 20;
    localparam int ROW_W    = 10;
    localparam int CH_LSB   = 28;
    localparam int CH_W     = 2;
    localparam int COL_LSB  = 20;
    localparam int COL_W    = 8;
    localparam int CDS_FLD_W = 20;
    localparam int NCOL_LSB = 0;

    typedef struct packed {
        logic              last;
        logic [WORD_W-1:0] word;
    } fifo_ent_t;

    function automatic logic [WORD_W-1:0] hdr_word(input logic [ROW_W-1:0] row,
                                                   input logic [COL_W-1:0] ncol);
        hdr_word = {TAG_HDR, row, 12'b0, ncol};
    endfunction

    // cds arrives zero-extended to the full low field so ADC_W stays a top-level choice
    function automatic logic [WORD_W-1:0] data_word(input logic [CH_W-1:0]      ch,
                                                    input logic [COL_W-1:0]     col,
                                                    input logic [CDS_FLD_W-1:0] cds);
        data_word = {TAG_DATA, ch, col, cds};
    endfunction

endpackage

// File: rtl/ro_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; rd_dat valid whenever !empty, 1-cycle write-to-visible.
// Writes while full are refused unless a read happens the same cycle.
module ro_sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_dat,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_rd;
    logic             do_wr;

    assign empty  = (count == '0);
    assign full   = (count == FULL_CNT);
    assign do_rd  = rd_en && !empty;
    assign do_wr  = wr_en && (!full || do_rd);
    // gate the read port so the output reads zero while empty and right after reset
    assign rd_dat = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            count <= count + {{AW{1'b0}}, do_wr} - {{AW{1'b0}}, do_rd};
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_dat;
    end

endmodule

// File: rtl/ro_cds_packer.sv
// Captures R/S ADC phases of a row, emits header + clamped R-S words; adc_valid(CAP_S) -> out_data in 3 cycles.
// Output is valid/ready through an FWFT FIFO; a push into a full FIFO is dropped and flagged.
module ro_cds_packer
    import ro_pkg::*;
#(
    parameter int ADC_W      = 12,
    parameter int NUM_CH     = 3,
    parameter int NUM_COL    = 4,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                    CLK,
    input  logic                    rst,
    input  logic                    READ_R,
    input  logic                    READ_S,
    input  logic [9:0]              ROWADD,
    input  logic                    adc_valid,
    input  logic [NUM_CH*ADC_W-1:0] adc_data,
    input  logic                    clr_err,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_data,
    output logic                    out_last,
    output logic                    busy,
    output logic                    overflow,
    output logic                    seq_err
);

    localparam int COL_IW = (NUM_COL > 1) ? $clog2(NUM_COL) : 1;
    localparam int CH_IW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COL - 1);
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);

    ro_state_e          state;
    ro_state_e          state_nxt;
    logic               read_r_q;
    logic               read_s_q;
    logic               r_rise;
    logic               s_rise;
    logic [ROW_W-1:0]   row_q;
    logic [COL_W-1:0]   col;
    logic [CH_W-1:0]    ch;
    logic [COL_IW-1:0]  col_idx;
    logic [CH_IW-1:0]   ch_idx;

    logic [ADC_W-1:0]   rbuf [NUM_COL][NUM_CH];
    logic [ADC_W-1:0]   sbuf [NUM_CH];
    logic [ADC_W-1:0]   r_sel;
    logic [ADC_W-1:0]   s_sel;
    logic [ADC_W-1:0]   cds;

    logic               start_row;
    logic               cap_r_beat;
    logic               hdr_push;
    logic               cap_s_beat;
    logic               ser_beat;
    logic               seq_set;
    logic               adc_ovf;

    logic               push_vld;
    fifo_ent_t          push_dat;
    logic               push_vld_q;
    fifo_ent_t          push_q;
    fifo_ent_t          rd_ent;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;
    logic               drop;

    assign r_rise  = READ_R && !read_r_q;
    assign s_rise  = READ_S && !read_s_q;
    assign col_idx = col[COL_IW-1:0];
    assign ch_idx  = ch[CH_IW-1:0];
    assign busy    = (state != IDLE);

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            read_r_q <= 1'b0;
            read_s_q <= 1'b0;
            state    <= IDLE;
        end else begin
            read_r_q <= READ_R;
            read_s_q <= READ_S;
            state    <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        start_row  = 1'b0;
        cap_r_beat = 1'b0;
        hdr_push   = 1'b0;
        cap_s_beat = 1'b0;
        ser_beat   = 1'b0;
        seq_set    = 1'b0;
        adc_ovf    = 1'b0;
        case (state)
            IDLE: begin
                if (s_rise) begin
                    seq_set = 1'b1;
                end else if (r_rise) begin
                    start_row = 1'b1;
                    state_nxt = CAP_R;
                end
            end
            CAP_R: begin
                // an early S phase abandons the row before anything reaches the FIFO
                if (s_rise) begin
                    seq_set   = 1'b1;
                    state_nxt = IDLE;
                end else if (adc_valid) begin
                    cap_r_beat = 1'b1;
                    if (col == LAST_COL) state_nxt = WAIT_S;
                end
            end
            WAIT_S: begin
                if (r_rise) seq_set = 1'b1;
                if (s_rise) begin
                    hdr_push  = 1'b1;
                    state_nxt = CAP_S;
                end
            end
            CAP_S: begin
                if (r_rise) seq_set = 1'b1;
                if (adc_valid) begin
                    cap_s_beat = 1'b1;
                    state_nxt  = SER;
                end
            end
            SER: begin
                if (r_rise) seq_set = 1'b1;
                if (adc_valid) adc_ovf = 1'b1;
                ser_beat = 1'b1;
                if (ch == LAST_CH) state_nxt = (col == LAST_COL) ? IDLE : CAP_S;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            row_q <= '0;
            col   <= '0;
            ch    <= '0;
        end else begin
            if (start_row) row_q <= ROWADD;
            if (start_row || hdr_push) begin
                col <= '0;
            end else if (cap_r_beat || (ser_beat && ch == LAST_CH)) begin
                col <= col + COL_W'(1);
            end
            if (cap_s_beat) begin
                ch <= '0;
            end else if (ser_beat) begin
                ch <= ch + CH_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < NUM_COL; c++) begin
                for (int k = 0; k < NUM_CH; k++) rbuf[c][k] <= '0;
            end
            for (int k = 0; k < NUM_CH; k++) sbuf[k] <= '0;
        end else begin
            if (cap_r_beat) begin
                for (int k = 0; k < NUM_CH; k++) rbuf[col_idx][k] <= adc_data[k*ADC_W +: ADC_W];
            end
            if (cap_s_beat) begin
                for (int k = 0; k < NUM_CH; k++) sbuf[k] <= adc_data[k*ADC_W +: ADC_W];
            end
        end
    end

    always_comb begin
        r_sel = rbuf[col_idx][ch_idx];
        s_sel = sbuf[ch_idx];
        cds   = (r_sel >= s_sel) ? (r_sel - s_sel) : '0;
    end

    always_comb begin
        push_vld = hdr_push || ser_beat;
        push_dat = '0;
        if (hdr_push) begin
            push_dat.word = hdr_word(row_q, COL_W'(NUM_COL));
        end else begin
            push_dat.word = data_word(ch, col, CDS_FLD_W'(cds));
            push_dat.last = (col == LAST_COL) && (ch == LAST_CH);
        end
    end

    // one register stage between the sequencer and the FIFO keeps cds math off the write path
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            push_vld_q <= 1'b0;
            push_q     <= '0;
        end else begin
            push_vld_q <= push_vld;
            push_q     <= push_dat;
        end
    end

    ro_sync_fifo #(
        .WIDTH ($bits(fifo_ent_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (CLK),
        .rst_n  (rst),
        .wr_en  (push_vld_q),
        .wr_dat (push_q),
        .rd_en  (pop),
        .rd_dat (rd_ent),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign out_data  = rd_ent.word;
    assign out_last  = rd_ent.last;
    assign drop      = push_vld_q && fifo_full && !pop;

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
            seq_err  <= 1'b0;
        end else begin
            if (drop || adc_ovf) overflow <= 1'b1;
            else if (clr_err)    overflow <= 1'b0;
            if (seq_set)         seq_err <= 1'b1;
            else if (clr_err)    seq_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ro_cds_packer.sv
// Scoreboard bench: two packers (FIFO depth 64 and 8) share stimulus; expected words come from a row model.
module tb_ro_cds_packer;

    localparam int ADC_W   = 12;
    localparam int NUM_CH  = 3;
    localparam int NUM_COL = 4;

    logic                    CLK = 1'b0;
    logic                    rst = 1'b1;
    logic                    READ_R = 1'b0;
    logic                    READ_S = 1'b0;
    logic [9:0]              ROWADD = '0;
    logic                    adc_valid = 1'b0;
    logic [NUM_CH*ADC_W-1:0] adc_data = '0;
    logic                    clr_err = 1'b0;
    logic                    ready_a = 1'b1;
    logic                    ready_b = 1'b1;

    logic        out_valid_a, out_last_a, busy_a, overflow_a, seq_err_a;
    logic [31:0] out_data_a;
    logic        out_valid_b, out_last_b, busy_b, overflow_b, seq_err_b;
    logic [31:0] out_data_b;

    int tests = 0;
    int fails = 0;
    int mode_a = 0;      // 0: always ready, 1: random, 2: stalled
    bit hold_b = 1'b0;
    int b_limit = 1000;
    int b_cnt = 0;

    logic [32:0] exp_a[$];
    logic [32:0] exp_b[$];
    logic [ADC_W-1:0] rv [NUM_COL][NUM_CH];
    logic [ADC_W-1:0] sv [NUM_COL][NUM_CH];

    always #5 CLK = ~CLK;

    ro_cds_packer #(.ADC_W(ADC_W), .NUM_CH(NUM_CH), .NUM_COL(NUM_COL), .FIFO_DEPTH(64)) dut_a (
        .CLK(CLK), .rst(rst), .READ_R(READ_R), .READ_S(READ_S), .ROWADD(ROWADD),
        .adc_valid(adc_valid), .adc_data(adc_data), .clr_err(clr_err),
        .out_valid(out_valid_a), .out_ready(ready_a), .out_data(out_data_a), .out_last(out_last_a),
        .busy(busy_a), .overflow(overflow_a), .seq_err(seq_err_a)
    );

    ro_cds_packer #(.ADC_W(ADC_W), .NUM_CH(NUM_CH), .NUM_COL(NUM_COL), .FIFO_DEPTH(8)) dut_b (
        .CLK(CLK), .rst(rst), .READ_R(READ_R), .READ_S(READ_S), .ROWADD(ROWADD),
        .adc_valid(adc_valid), .adc_data(adc_data), .clr_err(clr_err),
        .out_valid(out_valid_b), .out_ready(ready_b), .out_data(out_data_b), .out_last(out_last_b),
        .busy(busy_b), .overflow(overflow_b), .seq_err(seq_err_b)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---- reference model: words derived directly from the row's samples ----
    function automatic logic [32:0] model_hdr(input logic [9:0] row);
        logic [7:0] ncol;
        ncol = 8'(NUM_COL);
        return {1'b0, 2'b10, row, 12'h000, ncol};
    endfunction

    function automatic logic [32:0] model_data(input int c, input int k);
        logic [ADC_W-1:0] r, s, d;
        logic [1:0] chf;
        logic [7:0] colf;
        r = rv[c][k];
        s = sv[c][k];
        d = (r >= s) ? r - s : '0;
        chf = k[1:0];
        colf = c[7:0];
        return {(c == NUM_COL-1) && (k == NUM_CH-1), 2'b01, chf, colf, 8'h00, d};
    endfunction

    task automatic push_exp(input logic [32:0] e);
        exp_a.push_back(e);
        if (b_cnt < b_limit) begin
            exp_b.push_back(e);
            b_cnt++;
        end
    endtask

    // ---- monitor ----
    always @(negedge CLK) begin
        logic [32:0] e;
        if (rst && out_valid_a && ready_a) begin
            if (exp_a.size() == 0) check("a_unexpected_word", {31'b0, out_last_a, out_data_a}, 64'hDEAD);
            else begin
                e = exp_a.pop_front();
                check("a_word", {31'b0, out_last_a, out_data_a}, {31'b0, e});
            end
        end
        if (rst && out_valid_b && ready_b) begin
            if (exp_b.size() == 0) check("b_unexpected_word", {31'b0, out_last_b, out_data_b}, 64'hDEAD);
            else begin
                e = exp_b.pop_front();
                check("b_word", {31'b0, out_last_b, out_data_b}, {31'b0, e});
            end
        end
    end

    initial begin
        forever begin
            @(posedge CLK);
            #1;
            ready_a = (mode_a == 1) ? 1'($urandom_range(0, 1)) : (mode_a == 0);
            ready_b = !hold_b;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [NUM_CH*ADC_W-1:0] pack(input bit use_s, input int c);
        logic [NUM_CH*ADC_W-1:0] v;
        v = '0;
        for (int k = 0; k < NUM_CH; k++) v[k*ADC_W +: ADC_W] = use_s ? sv[c][k] : rv[c][k];
        return v;
    endfunction

    task automatic fill(input int rr, input int ss, input bit rnd);
        for (int c = 0; c < NUM_COL; c++)
            for (int k = 0; k < NUM_CH; k++) begin
                rv[c][k] = rnd ? 12'($urandom_range(0, 4095)) : 12'(rr);
                sv[c][k] = rnd ? 12'($urandom_range(0, 4095)) : 12'(ss);
            end
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
    endtask

    task automatic r_phase(input logic [9:0] row, input int nbeats);
        b_cnt = 0;
        ROWADD = row;
        READ_R = 1'b1;
        tick();
        for (int c = 0; c < nbeats; c++) begin
            adc_data = pack(1'b0, c);
            adc_valid = 1'b1;
            tick();
            adc_valid = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
        end
        READ_R = 1'b0;
        tick();
    endtask

    task automatic s_phase(input logic [9:0] row, input bit ser_poke);
        READ_S = 1'b1;
        push_exp(model_hdr(row));
        tick();
        for (int c = 0; c < NUM_COL; c++) begin
            adc_data = pack(1'b1, c);
            adc_valid = 1'b1;
            for (int k = 0; k < NUM_CH; k++) push_exp(model_data(c, k));
            tick();
            if (ser_poke && c == 0) begin
                adc_data = ~adc_data;
                tick();
            end
            adc_valid = 1'b0;
            repeat (3 + $urandom_range(0, 2)) tick();
        end
        READ_S = 1'b0;
        tick();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_a.size() != 0 || exp_b.size() != 0) && n < 2000) begin
            tick();
            n++;
        end
        if (n >= 2000) check("drain_timeout", 64'(exp_a.size() + exp_b.size()), 64'd0);
        repeat (4) tick();
        check("a_valid_after_drain", {63'b0, out_valid_a}, 64'd0);
        check("b_valid_after_drain", {63'b0, out_valid_b}, 64'd0);
        check("a_busy_after_row", {63'b0, busy_a}, 64'd0);
    endtask

    task automatic full_row(input logic [9:0] row);
        r_phase(row, NUM_COL);
        s_phase(row, 1'b0);
        drain();
    endtask

    initial begin
        logic [9:0] row;
        // reset state
        #1 rst = 1'b0;
        #2;
        check("rst_valid", {62'b0, out_valid_a, out_valid_b}, 64'd0);
        check("rst_data", {out_data_a, out_data_b}, 64'd0);
        check("rst_busy_flags", {58'b0, busy_a, busy_b, overflow_a, overflow_b, seq_err_a, seq_err_b}, 64'd0);
        repeat (3) tick();
        rst = 1'b1;
        tick();

        // nominal row
        fill(3000, 1000, 1'b0);
        full_row(10'd5);
        check("nominal_flags", {60'b0, overflow_a, overflow_b, seq_err_a, seq_err_b}, 64'd0);

        // clamp cases
        fill(100, 400, 1'b0);
        full_row(10'd17);
        fill(4095, 0, 1'b0);
        full_row(10'd1023);

        // random rows with random backpressure on the deep FIFO
        mode_a = 1;
        for (int i = 0; i < 6; i++) begin
            fill(0, 0, 1'b1);
            row = 10'($urandom_range(0, 1023));
            full_row(row);
        end
        mode_a = 0;
        check("random_flags", {60'b0, overflow_a, overflow_b, seq_err_a, seq_err_b}, 64'd0);

        // adc_valid during serialisation
        fill(0, 0, 1'b1);
        r_phase(10'd77, NUM_COL);
        s_phase(10'd77, 1'b1);
        drain();
        check("ser_poke_ovf", {62'b0, overflow_a, overflow_b}, 64'd3);
        pulse_clr();
        check("ser_poke_clr", {62'b0, overflow_a, overflow_b}, 64'd0);

        // backpressure on A (all 13 held) and overflow on B (depth 8)
        mode_a = 2;
        hold_b = 1'b1;
        b_limit = 8;
        tick();
        fill(0, 0, 1'b1);
        r_phase(10'd300, NUM_COL);
        s_phase(10'd300, 1'b0);
        repeat (5) tick();
        check("bp_hold_hdr", {31'b0, out_last_a, out_data_a}, {31'b0, model_hdr(10'd300)});
        check("bp_a_no_ovf", {63'b0, overflow_a}, 64'd0);
        check("ovf_b_set", {63'b0, overflow_b}, 64'd1);
        check("bp_busy", {63'b0, busy_a}, 64'd0);
        mode_a = 0;
        hold_b = 1'b0;
        drain();
        b_limit = 1000;
        check("bp_a_no_ovf_after", {63'b0, overflow_a}, 64'd0);
        pulse_clr();
        check("ovf_b_clr", {63'b0, overflow_b}, 64'd0);

        // sequencing errors
        READ_S = 1'b1;
        tick();
        check("seq_s_in_idle", {62'b0, seq_err_a, busy_a}, 64'd2);
        READ_S = 1'b0;
        tick();
        pulse_clr();
        check("seq_clr", {63'b0, seq_err_a}, 64'd0);
        fill(0, 0, 1'b1);
        r_phase(10'd9, 2);
        check("seq_in_cap_r", {63'b0, busy_a}, 64'd1);
        READ_S = 1'b1;
        tick();
        check("seq_s_in_cap_r", {62'b0, seq_err_a, busy_a}, 64'd2);
        READ_S = 1'b0;
        repeat (8) tick();
        check("seq_no_words", {62'b0, out_valid_a, out_valid_b}, 64'd0);
        pulse_clr();
        fill(0, 0, 1'b1);
        full_row(10'd10);
        check("seq_recover_flags", {62'b0, seq_err_a, overflow_a}, 64'd0);

        // READ_R in WAIT_S, then async reset while serialising
        fill(0, 0, 1'b1);
        r_phase(10'd600, NUM_COL);
        READ_R = 1'b1;
        tick();
        check("seq_r_in_wait", {62'b0, seq_err_a, busy_a}, 64'd3);
        READ_R = 1'b0;
        tick();
        READ_S = 1'b1;
        push_exp(model_hdr(10'd600));
        tick();
        adc_data = pack(1'b1, 0);
        adc_valid = 1'b1;
        tick();
        adc_valid = 1'b0;
        tick();
        check("mid_ser_busy", {63'b0, busy_a}, 64'd1);
        rst = 1'b0;
        #1;
        check("arst_valid", {62'b0, out_valid_a, out_valid_b}, 64'd0);
        check("arst_busy_flags", {58'b0, busy_a, busy_b, overflow_a, overflow_b, seq_err_a, seq_err_b}, 64'd0);
        check("arst_data", {30'b0, out_last_a, out_last_b, out_data_a}, 64'd0);
        exp_a.delete();
        exp_b.delete();
        READ_S = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        fill(0, 0, 1'b1);
        full_row(10'd601);
        check("post_rst_flags", {60'b0, overflow_a, overflow_b, seq_err_a, seq_err_b}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ro_cds_packer.md
Name: ro_cds_packer

Overview:
- Downstream of the row readout sequencer (Readout_v1); consumes its READ_R / READ_S phase strobes and ROWADD, plus per-channel ADC samples.
- Captures the reset-level (R) and signal-level (S) conversions of one row.
- Forms the correlated-double-sampling difference R−S per column and channel.
- Serialises the results, with a row header, into a valid/ready word stream for the host/TX path.

Parameters:
- ADC_W, 12, bits per ADC sample.
- NUM_CH, 3, parallel ADC channels (max 4).
- NUM_COL, 4, ADC beats per phase per row (max 255).
- FIFO_DEPTH, 64, output FIFO depth in words (power of 2).

Ports:
- CLK  in  1  system clock (100 MHz).
- rst  in  1  asynchronous, active-low reset.
- READ_R  in  1  level from readout; rising edge starts the R capture phase.
- READ_S  in  1  level from readout; rising edge starts the S capture phase.
- ROWADD  in  10  row address, sampled at READ_R rising edge.
- adc_valid  in  1  one-cycle strobe; adc_data is valid.
- adc_data  in  NUM_CH*ADC_W  channel k occupies bits [k*ADC_W +: ADC_W].
- clr_err  in  1  pulse; clears the sticky flags.
- out_valid  out  1  stream word available.
- out_ready  in  1  downstream accepts the word.
- out_data  out  32  stream word.
- out_last  out  1  marks the final word of a row.
- busy  out  1  high in any state except IDLE.
- overflow  out  1  sticky: word dropped, or adc_valid arrived during serialisation.
- seq_err  out  1  sticky: out-of-order READ_R / READ_S.

Behaviour:
- Reset (rst=0): all outputs 0, FIFO emptied, state IDLE, R buffer cleared, edge detectors cleared. Applies mid-row too; the partial row is discarded.
- Edge detect: READ_R and READ_S are registered; rising edge = current 1 and previous 0.
- FSM states and transitions:
  - IDLE: on READ_R↑, latch ROWADD, col=0, go to CAP_R.
  - CAP_R: each adc_valid stores all NUM_CH samples into rbuf[col], then col++. When col reaches NUM_COL, go to WAIT_S.
  - WAIT_S: on READ_S↑, push the header, col=0, go to CAP_S.
  - CAP_S: on adc_valid, latch the S samples and go to SER with ch=0.
  - SER: one FIFO push per cycle for ch=0..NUM_CH−1, then col++. If col==NUM_COL go to IDLE, else back to CAP_S.
- CDS arithmetic: cds = (R ≥ S) ? R−S : 0 (clamped, unsigned, ADC_W bits).
- Header word: [31:30]=2'b10, [29:20]=ROWADD, [19:8]=0, [7:0]=NUM_COL.
- Data word: [31:30]=2'b01, [29:28]=ch, [27:20]=col, [19:ADC_W]=0, [ADC_W-1:0]=cds.
- out_last=1 on the data word with col=NUM_COL−1 and ch=NUM_CH−1. It is stored in the FIFO alongside the word (33-bit entries).
- FIFO is first-word-fall-through:
  - out_valid rises the cycle after the first write into an empty FIFO.
  - A word pops when out_valid && out_ready.
  - out_data/out_last are held stable while out_valid && !out_ready.
  - Simultaneous push and pop while full is allowed (occupancy unchanged).
- Push while full and no pop that cycle: the word is dropped, overflow=1, row sequencing continues.
- adc_valid in SER: sample ignored, overflow=1.
- adc_valid in IDLE or WAIT_S: ignored, no flag.
- Sequencing errors:
  - READ_S↑ in IDLE or CAP_R: seq_err=1. From CAP_R, go to IDLE with no words pushed; in IDLE, stay.
  - READ_R↑ in WAIT_S, CAP_S or SER: seq_err=1, event ignored, current row completes normally.
- clr_err clears overflow/seq_err. A set and a clear in the same cycle: the set wins.
- Latency: adc_valid in CAP_S (FIFO empty, out_ready=1) → ch0 word on out_data 3 cycles later: latch, push, FWFT valid.

Decomposition:
- Package ro_pkg holds:
  - state enum (IDLE, CAP_R, WAIT_S, CAP_S, SER);
  - tag constants TAG_HDR=2'b10 and TAG_DATA=2'b01;
  - word field offsets.
- Sub-module ro_sync_fifo: single-clock FWFT FIFO with parameters WIDTH and DEPTH, ports full/empty, async active-low reset.

Test Plan (NUM_CH=3, NUM_COL=4, ADC_W=12):
- Nominal row: ROWADD=10'd5, READ_R↑, 4 beats R=12'd3000; READ_S↑, 4 beats S=12'd1000 on all channels, out_ready=1 → header 32'h8050_0004, then 12 data words with cds=12'd2000 in order (col0 ch0..2, col1…). out_last only on col=3 ch=2. busy falls after the last push. Flags stay 0.
- Clamp: R=12'd100, S=12'd400 → every cds=0. R=12'd4095, S=0 → cds=12'hFFF.
- Backpressure: out_ready=0 for the whole row → 13 words held in the FIFO, out_data frozen on the header. Release out_ready → 13 consecutive pops with no loss, overflow=0.
- Overflow: FIFO_DEPTH=8, out_ready=0 → first 8 words kept, remaining 5 dropped, overflow=1. Pulse clr_err → overflow=0.
- Sequencing: READ_S↑ after 2 R beats → seq_err=1, state IDLE, no words emitted. A following full valid row still emits 13 correct words.
- Async reset mid-SER: rst low → out_valid=0, busy=0, FIFO empty, flags 0 immediately without a clock. After release, a fresh row completes correctly.
